// File: rtl/mul_pkg.sv
// Shared definitions for the multiplier operand feeder: default width,
// feeder state encoding and the product returned for zero-operand jobs.
package mul_pkg;

    localparam int MUL_W = 16;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_LOAD_A = 3'd2,
        S_LOAD_B = 3'd3,
        S_RUN    = 3'd4,
        S_RESULT = 3'd5,
        S_DRAIN  = 3'd6
    } mul_feed_state_t;

    localparam logic [MUL_W-1:0] BYPASS_ZERO = {MUL_W{1'b0}};

endpackage

// File: rtl/mul_result_reg.sv
// Result holding register with the res_valid/res_ready handshake; the value
// stays stable while res_valid is high and the consumer has not accepted it.
module mul_result_reg
    import mul_pkg::*;
#(
    parameter int W = MUL_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         res_ready,
    output logic         res_valid,
    output logic [W-1:0] res_data,
    output logic         fire
);

    logic         valid_r;
    logic [W-1:0] data_r;

    assign res_valid = valid_r;
    assign res_data  = data_r;
    assign fire      = valid_r & res_ready;

    // Capture a new result, or clear valid once the consumer takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= 1'b0;
            data_r  <= {W{1'b0}};
        end else if (load) begin
            valid_r <= 1'b1;
            data_r  <= load_data;
        end else if (fire) begin
            valid_r <= 1'b0;
            data_r  <= data_r;
        end else begin
            valid_r <= valid_r;
            data_r  <= data_r;
        end
    end

endmodule

// File: rtl/mul_operand_feeder.sv
// Sequences operand pairs onto a repeated-addition multiplier and returns the
// product. Optional operand swap (smaller value as repeat count): MUL_FEEDER_SWAP_EN.
module mul_operand_feeder
    import mul_pkg::*;
#(
    parameter int W = MUL_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         start,
    output logic [W-1:0] datain,
    input  logic         done,
    input  logic [W-1:0] product,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_data,
    output logic         busy
);

    mul_feed_state_t state_r, state_n;
    logic [W-1:0]    a_r, b_r;
    logic            used_r;
    logic            start_r, in_ready_r, busy_r;
    logic [W-1:0]    datain_r, datain_n;
    logic [W-1:0]    a_sel_s, b_sel_s;
    logic            accept_s, zero_s, load_s, fire_s;
    logic [W-1:0]    load_data_s;

    assign in_ready = in_ready_r;
    assign start    = start_r;
    assign datain   = datain_r;
    assign busy     = busy_r;
    assign accept_s = in_valid & in_ready_r;
    assign zero_s   = (in_a == {W{1'b0}}) | (in_b == {W{1'b0}});

    // Operand ordering at accept; the product does not depend on it.
    always_comb begin
        a_sel_s = in_a;
        b_sel_s = in_b;
`ifdef MUL_FEEDER_SWAP_EN
        if (in_b > in_a) begin
            a_sel_s = in_b;
            b_sel_s = in_a;
        end else begin
            a_sel_s = in_a;
            b_sel_s = in_b;
        end
`endif
    end

    // Next-state logic and result-register load requests.
    always_comb begin
        state_n     = state_r;
        load_s      = 1'b0;
        load_data_s = W'(BYPASS_ZERO);
        case (state_r)
            S_IDLE: begin
                if (accept_s && zero_s) begin
                    state_n = S_RESULT;
                    load_s  = 1'b1;
                end else if (accept_s) begin
                    state_n = S_START;
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_START:  state_n = S_LOAD_A;
            S_LOAD_A: state_n = S_LOAD_B;
            S_LOAD_B: state_n = S_RUN;
            S_RUN: begin
                if (done) begin
                    state_n     = S_RESULT;
                    load_s      = 1'b1;
                    load_data_s = product;
                end else begin
                    state_n = S_RUN;
                end
            end
            S_RESULT: begin
                if (fire_s) begin
                    state_n = used_r ? S_DRAIN : S_IDLE;
                end else begin
                    state_n = S_RESULT;
                end
            end
            // The multiplier may still hold done high; never restart under it.
            S_DRAIN: begin
                if (!done) begin
                    state_n = S_IDLE;
                end else begin
                    state_n = S_DRAIN;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Bus value for the cycle the FSM is about to enter.
    always_comb begin
        datain_n = {W{1'b0}};
        case (state_n)
            S_LOAD_A: datain_n = a_r;
            S_LOAD_B: datain_n = b_r;
            default:  datain_n = {W{1'b0}};
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Operand latch; used_r remembers whether the multiplier was started.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r    <= {W{1'b0}};
            b_r    <= {W{1'b0}};
            used_r <= 1'b0;
        end else if (accept_s) begin
            a_r    <= a_sel_s;
            b_r    <= b_sel_s;
            used_r <= ~zero_s;
        end else begin
            a_r    <= a_r;
            b_r    <= b_r;
            used_r <= used_r;
        end
    end

    // Outputs registered from the next state so they align with the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_r    <= 1'b0;
            datain_r   <= {W{1'b0}};
            in_ready_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            start_r    <= (state_n == S_START);
            datain_r   <= datain_n;
            in_ready_r <= (state_n == S_IDLE);
            busy_r     <= (state_n != S_IDLE);
        end
    end

    mul_result_reg #(.W(W)) u_result (
        .clk       (clk),
        .rst       (rst),
        .load      (load_s),
        .load_data (load_data_s),
        .res_ready (res_ready),
        .res_valid (res_valid),
        .res_data  (res_data),
        .fire      (fire_s)
    );

endmodule

// File: tb/tb_mul_operand_feeder.sv
// Self-checking bench for mul_operand_feeder with a behavioural repeated-addition
// multiplier; honours MUL_FEEDER_SWAP_EN when computing expected latency/bus order.
module tb_mul_operand_feeder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = 16'd0;
    logic [15:0] in_b = 16'd0;
    logic        start;
    logic [15:0] datain;
    logic        done = 1'b0;
    logic [15:0] product = 16'd0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [15:0] res_data;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mul_operand_feeder #(.W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .start(start), .datain(datain),
        .done(done), .product(product), .res_valid(res_valid),
        .res_ready(res_ready), .res_data(res_data), .busy(busy)
    );

    // Behavioural multiplier: start, then A and B on datain, B loop cycles,
    // then done held for a random number of extra cycles.
    int          m_ph = 0;
    int          m_cnt = 0;
    int          m_hold = 0;
    logic [15:0] m_a = 16'd0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ph <= 0; m_cnt <= 0; m_hold <= 0; done <= 1'b0; product <= 16'd0;
        end else begin
            case (m_ph)
                0: if (start) m_ph <= 1;
                1: begin m_a <= datain; m_ph <= 2; end
                2: begin m_cnt <= int'(datain); product <= 16'd0; m_ph <= 3; end
                3: begin
                    product <= product + m_a;
                    if (m_cnt <= 1) begin
                        done <= 1'b1; m_hold <= int'($urandom_range(0, 6)); m_ph <= 4;
                    end else begin
                        m_cnt <= m_cnt - 1;
                    end
                end
                default: begin
                    if (m_hold == 0) begin done <= 1'b0; m_ph <= 0; end
                    else m_hold <= m_hold - 1;
                end
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_idle();
        int g = 0;
        while (in_ready !== 1'b1 && g < 100) begin @(negedge clk); g++; end
        chk("idle_ready", {31'd0, in_ready}, 32'd1);
        chk("idle_busy", {31'd0, busy}, 32'd0);
    endtask

    task automatic do_job(input logic [15:0] a, input logic [15:0] b,
                          input int hold, input bit early);
        longint      full;
        logic [15:0] exp_p, lo, hi;
        int          lat, c, n_start, first_start, rv_cyc;
        logic [15:0] d2, d3, got;
        bit          bypass;
        bypass = (a == 16'd0) || (b == 16'd0);
        full   = longint'(a) * longint'(b);
        exp_p  = bypass ? 16'd0 : 16'(full % 65536);
        lo = a; hi = b;
`ifdef MUL_FEEDER_SWAP_EN
        if (b > a) begin lo = b; hi = a; end
`endif
        lat = bypass ? 1 : 5 + int'(hi);
        wait_idle();
        in_valid = 1'b1; in_a = a; in_b = b; res_ready = early;
        @(negedge clk);
        in_valid = 1'b0;
        n_start = 0; first_start = -1; rv_cyc = -1; d2 = 16'hxxxx; d3 = 16'hxxxx; got = 16'd0;
        for (c = 1; c < 600; c++) begin
            if (start) begin n_start++; if (first_start < 0) first_start = c; end
            if (c == 2) d2 = datain;
            if (c == 3) d3 = datain;
            if (res_valid) begin rv_cyc = c; got = res_data; break; end
            @(negedge clk);
        end
        chk("res_valid_cycle", rv_cyc, lat);
        chk("res_data", {16'd0, got}, {16'd0, exp_p});
        chk("start_count", n_start, bypass ? 0 : 1);
        if (!bypass) begin
            chk("start_cycle", first_start, 1);
            chk("datain_a", {16'd0, d2}, {16'd0, lo});
            chk("datain_b", {16'd0, d3}, {16'd0, hi});
        end
        if (early) begin
            @(negedge clk);
            res_ready = 1'b0;
            chk("early_drop", {31'd0, res_valid}, 32'd0);
        end else begin
            in_valid = 1'b1; in_a = 16'($urandom); in_b = 16'($urandom);
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                chk("hold_valid", {31'd0, res_valid}, 32'd1);
                chk("hold_data", {16'd0, res_data}, {16'd0, exp_p});
                chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
                chk("hold_start", {31'd0, start}, 32'd0);
            end
            in_valid = 1'b0; res_ready = 1'b1;
            @(negedge clk);
            res_ready = 1'b0;
            chk("hs_drop", {31'd0, res_valid}, 32'd0);
        end
    endtask

    initial begin
        bit seen;
        logic [15:0] ra, rb;
        #12;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_start", {31'd0, start}, 32'd0);
        chk("rst_datain", {16'd0, datain}, 32'd0);
        chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_res_data", {16'd0, res_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);

        do_job(16'd5, 16'd3, 0, 1'b0);
        do_job(16'd7, 16'd0, 0, 1'b0);
        do_job(16'd0, 16'd9, 0, 1'b1);
        do_job(16'd300, 16'd300, 0, 1'b1);
        do_job(16'd6, 16'd4, 10, 1'b0);
        do_job(16'd3, 16'd200, 0, 1'b0);

        // Reset in the middle of a long multiply.
        wait_idle();
        in_valid = 1'b1; in_a = 16'd4; in_b = 16'd50;
        @(negedge clk); in_valid = 1'b0;
        repeat (20) @(negedge clk);
        chk("run_busy", {31'd0, busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("arst_datain", {16'd0, datain}, 32'd0);
        @(negedge clk); rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (res_valid || start) seen = 1'b1;
        end
        chk("no_result_after_rst", {31'd0, seen}, 32'd0);
        do_job(16'd2, 16'd2, 0, 1'b0);

        for (int k = 0; k < 10; k++) begin
            ra = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom);
            rb = 16'($urandom_range(0, 40));
            do_job(ra, rb, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
